// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
// Holds the pattern-mode enum, RGB payload struct, colour constants,
// default active-area size and the mode-advance helper.
package vga_pattern_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned CH_W      = 10;
    localparam int unsigned DEF_H_ACT = 640;
    localparam int unsigned DEF_V_ACT = 480;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BOX     = 2'd2,
        MODE_GRAD    = 2'd3
    } mode_e;

    typedef struct packed {
        logic [CH_W-1:0] red;
        logic [CH_W-1:0] green;
        logic [CH_W-1:0] blue;
    } rgb_t;

    // One axis of box motion: dir = 1 means moving towards larger coordinates.
    typedef struct packed {
        logic               dir;
        logic [COORD_W-1:0] pos;
    } axis_t;

    localparam rgb_t RGB_WHITE   = '{red: 10'h3FF, green: 10'h3FF, blue: 10'h3FF};
    localparam rgb_t RGB_YELLOW  = '{red: 10'h3FF, green: 10'h3FF, blue: 10'h000};
    localparam rgb_t RGB_CYAN    = '{red: 10'h000, green: 10'h3FF, blue: 10'h3FF};
    localparam rgb_t RGB_GREEN   = '{red: 10'h000, green: 10'h3FF, blue: 10'h000};
    localparam rgb_t RGB_MAGENTA = '{red: 10'h3FF, green: 10'h000, blue: 10'h3FF};
    localparam rgb_t RGB_RED     = '{red: 10'h3FF, green: 10'h000, blue: 10'h000};
    localparam rgb_t RGB_BLUE    = '{red: 10'h000, green: 10'h000, blue: 10'h3FF};
    localparam rgb_t RGB_BLACK   = '{red: 10'h000, green: 10'h000, blue: 10'h000};

    // Next pattern in the cycle; MODE_GRAD wraps to MODE_BARS.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(2'(m + 2'd1));
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker.
// Ports: Clock, Resetn (async active-low), frame_tick (one-cycle strobe),
//        box_x / box_y (top-left corner of the box, pixels).
// Each axis moves STEP pixels per frame and reverses at the active-area edges.
module vga_box_mover
    import vga_pattern_pkg::*;
#(
    parameter int unsigned H_ACT    = DEF_H_ACT,
    parameter int unsigned V_ACT    = DEF_V_ACT,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2
)(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               frame_tick,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y
);

    // Largest legal top-left position on each axis.
    localparam logic [11:0] X_LIM = 12'(H_ACT - BOX_SIZE);
    localparam logic [11:0] Y_LIM = 12'(V_ACT - BOX_SIZE);

    axis_t x_q, y_q;

    // pos + BOX_SIZE + STEP > ACT is evaluated as pos + STEP > ACT - BOX_SIZE.
    function automatic axis_t advance(input axis_t a, input logic [11:0] lim);
        axis_t n;
        n = a;
        if (a.dir) begin
            if (12'(a.pos) + 12'(STEP) > lim) begin
                n.pos = COORD_W'(lim);
                n.dir = 1'b0;
            end else begin
                n.pos = a.pos + COORD_W'(STEP);
            end
        end else begin
            if (12'(a.pos) < 12'(STEP)) begin
                n.pos = '0;
                n.dir = 1'b1;
            end else begin
                n.pos = a.pos - COORD_W'(STEP);
            end
        end
        return n;
    endfunction

    // Position registers, updated once per frame.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            x_q <= '{dir: 1'b1, pos: '0};
            y_q <= '{dir: 1'b1, pos: '0};
        end else if (frame_tick) begin
            x_q <= advance(x_q, X_LIM);
            y_q <= advance(y_q, Y_LIM);
        end
    end

    assign box_x = x_q.pos;
    assign box_y = y_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, checkerboard, bouncing box, gradient.
// Ports: Clock, Resetn (async active-low), iCoord_X/iCoord_Y (pixel coordinates),
//        iPB_n (active-low mode button), oRed/oGreen/oBlue (registered colour),
//        oMode (current pattern), oFrame_Count (frames elapsed, mod 256).
// Build option: VGA_PATTERN_AUTO_CYCLE_EN also advances the mode every 256 frames.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int unsigned H_ACT    = DEF_H_ACT,
    parameter int unsigned V_ACT    = DEF_V_ACT,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2
)(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [COORD_W-1:0] iCoord_X,
    input  logic [COORD_W-1:0] iCoord_Y,
    input  logic               iPB_n,
    output logic [CH_W-1:0]    oRed,
    output logic [CH_W-1:0]    oGreen,
    output logic [CH_W-1:0]    oBlue,
    output logic [1:0]         oMode,
    output logic [7:0]         oFrame_Count
);

    localparam int unsigned BAR_W = H_ACT / 8;

    logic               pb_s1, pb_s2, pb_q;
    logic               press_c;
    logic               frame_tick_c;
    logic [7:0]         frame_count_q;
    mode_e              mode_q, mode_nxt;
    logic [COORD_W-1:0] box_x, box_y;
    rgb_t               rgb_c, rgb_q;
    logic [2:0]         bar_idx;
    logic               active_c, in_box_c;

    // Button synchronizer plus one extra flop for falling-edge detection.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pb_s1 <= 1'b1;
            pb_s2 <= 1'b1;
            pb_q  <= 1'b1;
        end else begin
            pb_s1 <= iPB_n;
            pb_s2 <= pb_s1;
            pb_q  <= pb_s2;
        end
    end

    assign press_c      = pb_q & ~pb_s2;
    assign frame_tick_c = (iCoord_Y == COORD_W'(V_ACT)) && (iCoord_X == '0);

    // Frame counter, wraps naturally at 8 bits.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) frame_count_q <= '0;
        else if (frame_tick_c) frame_count_q <= frame_count_q + 8'd1;
    end

    // Mode FSM state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) mode_q <= MODE_BARS;
        else         mode_q <= mode_nxt;
    end

    // Mode FSM next state; auto-advance and a press may stack in one cycle.
    always_comb begin
        mode_nxt = mode_q;
`ifdef VGA_PATTERN_AUTO_CYCLE_EN
        if (frame_tick_c && (frame_count_q == 8'hFF)) mode_nxt = next_mode(mode_nxt);
`endif
        if (press_c) mode_nxt = next_mode(mode_nxt);
    end

    vga_box_mover #(
        .H_ACT    (H_ACT),
        .V_ACT    (V_ACT),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .frame_tick (frame_tick_c),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // Pixel colour for the current coordinate.
    always_comb begin
        rgb_c    = RGB_BLACK;
        bar_idx  = '0;
        active_c = (11'(iCoord_X) < 11'(H_ACT)) && (11'(iCoord_Y) < 11'(V_ACT));
        in_box_c = (iCoord_X >= box_x) && (11'(iCoord_X) < 11'(box_x) + 11'(BOX_SIZE)) &&
                   (iCoord_Y >= box_y) && (11'(iCoord_Y) < 11'(box_y) + 11'(BOX_SIZE));
        for (int unsigned i = 1; i < 8; i++) begin
            if (11'(iCoord_X) >= 11'(i * BAR_W)) bar_idx = 3'(i);
        end
        if (active_c) begin
            case (mode_q)
                MODE_BARS: begin
                    case (bar_idx)
                        3'd0:    rgb_c = RGB_WHITE;
                        3'd1:    rgb_c = RGB_YELLOW;
                        3'd2:    rgb_c = RGB_CYAN;
                        3'd3:    rgb_c = RGB_GREEN;
                        3'd4:    rgb_c = RGB_MAGENTA;
                        3'd5:    rgb_c = RGB_RED;
                        3'd6:    rgb_c = RGB_BLUE;
                        default: rgb_c = RGB_BLACK;
                    endcase
                end
                MODE_CHECKER: rgb_c = (iCoord_X[5] ^ iCoord_Y[5]) ? RGB_WHITE : RGB_BLACK;
                MODE_BOX:     rgb_c = in_box_c ? RGB_RED
                                               : '{red: '0, green: '0, blue: 10'h0FF};
                MODE_GRAD:    rgb_c = '{red: iCoord_X, green: iCoord_Y, blue: '0};
                default:      rgb_c = RGB_BLACK;
            endcase
        end
    end

    // One-cycle colour pipeline.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) rgb_q <= RGB_BLACK;
        else         rgb_q <= rgb_c;
    end

    assign oRed         = rgb_q.red;
    assign oGreen       = rgb_q.green;
    assign oBlue        = rgb_q.blue;
    assign oMode        = mode_q;
    assign oFrame_Count = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen against a behavioural pattern model.
module tb_vga_pattern_gen;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int BOX = 32;
    localparam int STP = 2;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [9:0] iCoord_X, iCoord_Y;
    logic       iPB_n;
    logic [9:0] oRed, oGreen, oBlue;
    logic [1:0] oMode;
    logic [7:0] oFrame_Count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode, m_count, m_bx, m_by;
    bit m_dx, m_dy;

    vga_pattern_gen #(.H_ACT(H), .V_ACT(V), .BOX_SIZE(BOX), .STEP(STP)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .iCoord_X     (iCoord_X),
        .iCoord_Y     (iCoord_Y),
        .iPB_n        (iPB_n),
        .oRed         (oRed),
        .oGreen       (oGreen),
        .oBlue        (oBlue),
        .oMode        (oMode),
        .oFrame_Count (oFrame_Count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] model_rgb(input int x, input int y);
        if (x >= H || y >= V) return 30'h0;
        case (m_mode)
            0: begin
                case (x / 80)
                    0: return {10'h3FF, 10'h3FF, 10'h3FF};
                    1: return {10'h3FF, 10'h3FF, 10'h000};
                    2: return {10'h000, 10'h3FF, 10'h3FF};
                    3: return {10'h000, 10'h3FF, 10'h000};
                    4: return {10'h3FF, 10'h000, 10'h3FF};
                    5: return {10'h3FF, 10'h000, 10'h000};
                    6: return {10'h000, 10'h000, 10'h3FF};
                    default: return 30'h0;
                endcase
            end
            1: return (((x / 32) % 2) != ((y / 32) % 2)) ? {10'h3FF, 10'h3FF, 10'h3FF} : 30'h0;
            2: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX)
                      ? {10'h3FF, 10'h000, 10'h000} : {10'h000, 10'h000, 10'h0FF};
            default: return {10'(x), 10'(y), 10'h000};
        endcase
    endfunction

    task automatic move_axis(input int pos, input bit dir, input int act,
                             output int np, output bit nd);
        if (dir) begin
            if (pos + BOX + STP > act) begin np = act - BOX; nd = 1'b0; end
            else begin np = pos + STP; nd = 1'b1; end
        end else begin
            if (pos < STP) begin np = 0; nd = 1'b1; end
            else begin np = pos - STP; nd = 1'b0; end
        end
    endtask

    task automatic model_tick();
        int np; bit nd;
        move_axis(m_bx, m_dx, H, np, nd); m_bx = np; m_dx = nd;
        move_axis(m_by, m_dy, V, np, nd); m_by = np; m_dy = nd;
        m_count = (m_count + 1) % 256;
`ifdef VGA_PATTERN_AUTO_CYCLE_EN
        if (m_count == 0) m_mode = (m_mode + 1) % 4;
`endif
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1;
    endtask

    // One clock with the given coordinate; optionally check the registered colour.
    task automatic drive(input int x, input int y, input bit chk);
        logic [29:0] exp;
        exp = model_rgb(x, y);
        iCoord_X = 10'(x);
        iCoord_Y = 10'(y);
        @(posedge Clock); #1;
        if (x == 0 && y == V) model_tick();
        if (chk) check("rgb", {2'b0, oRed, oGreen, oBlue}, {2'b0, exp});
    endtask

    task automatic drive_random(input int n);
        int x, y;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 700);
            y = $urandom_range(0, 520);
            if (x == 0 && y == V) x = 1;
            drive(x, y, 1'b1);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_mode"},  32'(oMode), 32'(m_mode));
        check({tag, "_count"}, 32'(oFrame_Count), 32'(m_count));
        check({tag, "_box_x"}, 32'(dut.u_box.box_x), 32'(m_bx));
        check({tag, "_box_y"}, 32'(dut.u_box.box_y), 32'(m_by));
    endtask

    // Button held low for low_cycles clocks; mode must step 3 clocks after the fall.
    task automatic press(input int low_cycles, input bit tick_at3);
        int old;
        old = m_mode;
        iPB_n = 1'b0;
        for (int k = 1; k <= low_cycles; k++) begin
            if (k == 3 && tick_at3) drive(0, V, 1'b1);
            else drive(700, 10, 1'b1);
            if (k == 2) check("press_early", 32'(oMode), 32'(old));
            if (k == 3) begin
                m_mode = (m_mode + 1) % 4;
                check("press_step", 32'(oMode), 32'(m_mode));
            end
        end
        iPB_n = 1'b1;
        for (int k = 0; k < 4; k++) drive(700, 10, 1'b1);
        check("press_once", 32'(oMode), 32'(m_mode));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) drive(0, V, 1'b1);
    endtask

    initial begin
        Resetn = 1'b0; iPB_n = 1'b1; iCoord_X = 10'd100; iCoord_Y = 10'd10;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        check("rst_rgb", {2'b0, oRed, oGreen, oBlue}, 32'h0);
        check_state("rst");
        Resetn = 1'b1;

        // Bars: directed yellow, out-of-range, then random
        drive(100, 10, 1'b1);
        check("yellow", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'h3FF, 10'h3FF, 10'h000});
        drive(700, 10, 1'b1);
        drive(100, 480, 1'b1);
        drive(639, 0, 1'b1);
        drive(80, 0, 1'b1);
        drive_random(40);

        // Checker
        press(5, 1'b0);
        drive(32, 0, 1'b1);
        check("checker_white", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'h3FF, 10'h3FF, 10'h3FF});
        drive(32, 32, 1'b1);
        drive_random(30);

        // Box at reset position
        press(5, 1'b0);
        drive(31, 31, 1'b1);
        drive(32, 31, 1'b1);
        drive(0, 32, 1'b1);
        drive_random(30);

        // Gradient
        press(5, 1'b0);
        drive(639, 479, 1'b1);
        check("grad", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'h27F, 10'h1DF, 10'h000});
        drive(640, 479, 1'b1);
        drive_random(30);

        // Fourth press wraps to bars
        press(5, 1'b0);
        check("wrap_bars", 32'(oMode), 32'd0);

        // Three frames
        frames(3);
        check_state("three_frames");
        check("three_bx", 32'(dut.u_box.box_x), 32'd6);

        // Press and frame tick in the same cycle
        press(5, 1'b1);
        check_state("press_tick");

        // Move to box mode and run box to the right edge
        press(3, 1'b0);
        while (m_bx != 606) begin
            drive(0, V, 1'b1);
            drive(m_bx + BOX - 1, m_by, 1'b1);
            drive(m_bx + BOX, m_by + BOX - 1, 1'b1);
            if (m_bx > 0) drive(m_bx - 1, m_by, 1'b1);
            drive_random(1);
        end
        check_state("at_606");
        for (int i = 0; i < 3; i++) begin
            drive(0, V, 1'b1);
            check_state("edge");
            drive(m_bx + BOX - 1, m_by + BOX - 1, 1'b1);
            drive(m_bx + BOX, m_by, 1'b1);
        end
        check("final_bx", 32'(dut.u_box.box_x), 32'd606);

        // Mid-frame asynchronous reset
        drive_random(5);
        @(posedge Clock); #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        check("midrst_rgb", {2'b0, oRed, oGreen, oBlue}, 32'h0);
        check_state("midrst");
        @(posedge Clock); #1;
        Resetn = 1'b1;
        drive_random(5);
        frames(1);
        check("after_rst_count", 32'(oFrame_Count), 32'd1);

        // 256-frame wrap, plain and with a coincident press
        press(3, 1'b0);
        frames(254);
        check_state("count_255");
        frames(1);
        check_state("wrap");
        frames(255);
        check_state("count_255b");
        press(5, 1'b1);
        check_state("wrap_press");
        drive_random(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
